major_state_sequencer: RTL

MAJOR_STATE_SEQUENCER -- requirements
Module: major_state_sequencer

---
 rtl/major_state_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/major_state_sequencer.sv
// Major-state sequencer: FETCH, AUTOINC1/2, INDIRECT, EXEC1..EXECn, each lasting PHASES cycles.
// Define SEQUENCER_STEPM_EN to add single-major-state stepping with a retained resume position.
module major_state_sequencer #(
    parameter int unsigned NSTEPS = 6,
    parameter int unsigned PHASES = 4
) (
    input  logic              SYSCLK,
    input  logic              CLEAR_N,
    input  logic              RUN,
    input  logic              HALT,
    input  logic              STEPI,
    input  logic              STEPM,
    input  logic              NOAUTO,
    input  logic              NOIND,
    input  logic              DONE,
    output logic [PHASES-1:0] PH,
    output logic              CK_FETCH,
    output logic              CK_AUTOINC1,
    output logic              CK_AUTOINC2,
    output logic              CK_INDIRECT,
    output logic [NSTEPS-1:0] CK_EXEC,
    output logic              STB_FETCH,
    output logic              STB_AUTOINC1,
    output logic              STB_AUTOINC2,
    output logic              STB_INDIRECT,
    output logic [NSTEPS-1:0] STB_EXEC,
    output logic              RUNNING,
    output logic              OVERRUN
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_AUTOINC1,
        ST_AUTOINC2,
        ST_INDIRECT,
        ST_EXEC
    } state_t;

    localparam logic [3:0]        LAST_PHASE = 4'(PHASES - 1);
    localparam logic [3:0]        LAST_STEP  = 4'(NSTEPS - 1);
    localparam logic [PHASES-1:0] PH_ONE     = {{(PHASES-1){1'b0}}, 1'b1};
    localparam logic [NSTEPS-1:0] EXEC_ONE   = {{(NSTEPS-1){1'b0}}, 1'b1};

    state_t     state_q, state_d, succ_state, start_state;
    logic [3:0] phase_q, phase_d;
    logic [3:0] step_q, step_d, succ_step, start_step;
    logic       overrun_q, overrun_d;
    logic       single_q, single_d;
    logic       run_q, stepi_q;
    logic       run_edge, stepi_edge;
    logic       last_phase, done_hit, leave, to_idle;

    assign run_edge   = RUN & ~run_q;
    assign stepi_edge = STEPI & ~stepi_q;
    assign last_phase = (phase_q == LAST_PHASE);
    assign done_hit   = (state_q == ST_EXEC) && DONE;
    assign leave      = last_phase || done_hit;

`ifdef SEQUENCER_STEPM_EN
    state_t     resume_state_q, resume_state_d;
    logic [3:0] resume_step_q, resume_step_d;
    logic       stepm_q, stepm_edge;
    logic       stepm_mode_q, stepm_mode_d;

    assign stepm_edge  = STEPM & ~stepm_q;
    assign start_state = resume_state_q;
    assign start_step  = resume_step_q;
    // A stepped major state always parks in IDLE, whatever its successor is.
    assign to_idle     = stepm_mode_q ||
                         ((succ_state == ST_FETCH) && (HALT || single_q));

    always_ff @(posedge SYSCLK) begin
        if (!CLEAR_N) begin
            resume_state_q <= ST_FETCH;
            resume_step_q  <= '0;
            stepm_mode_q   <= 1'b0;
            stepm_q        <= STEPM;
        end else begin
            resume_state_q <= resume_state_d;
            resume_step_q  <= resume_step_d;
            stepm_mode_q   <= stepm_mode_d;
            stepm_q        <= STEPM;
        end
    end
`else
    logic unused_stepm;

    assign unused_stepm = STEPM;
    assign start_state  = ST_FETCH;
    assign start_step   = '0;
    assign to_idle      = (succ_state == ST_FETCH) && (HALT || single_q);
`endif

    always_comb begin
        succ_state = ST_FETCH;
        succ_step  = '0;
        case (state_q)
            ST_FETCH:    succ_state = NOIND ? ST_EXEC : (NOAUTO ? ST_INDIRECT : ST_AUTOINC1);
            ST_AUTOINC1: succ_state = ST_AUTOINC2;
            ST_AUTOINC2: succ_state = ST_INDIRECT;
            ST_INDIRECT: succ_state = ST_EXEC;
            ST_EXEC: begin
                if (!DONE && (step_q != LAST_STEP)) begin
                    succ_state = ST_EXEC;
                    succ_step  = step_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        step_d    = step_q;
        overrun_d = overrun_q;
        single_d  = single_q;
`ifdef SEQUENCER_STEPM_EN
        resume_state_d = resume_state_q;
        resume_step_d  = resume_step_q;
        stepm_mode_d   = stepm_mode_q;
`endif
        if (state_q == ST_IDLE) begin
            phase_d = '0;
            if (stepi_edge || run_edge) begin
                state_d  = start_state;
                step_d   = start_step;
                single_d = stepi_edge;
            end
`ifdef SEQUENCER_STEPM_EN
            else if (stepm_edge) begin
                state_d      = start_state;
                step_d       = start_step;
                stepm_mode_d = 1'b1;
            end
`endif
        end else if (leave) begin
            phase_d = '0;
            if ((state_q == ST_EXEC) && last_phase && (step_q == LAST_STEP) && !DONE) begin
                overrun_d = 1'b1;
            end
            if (to_idle) begin
                state_d  = ST_IDLE;
                step_d   = '0;
                single_d = 1'b0;
`ifdef SEQUENCER_STEPM_EN
                resume_state_d = succ_state;
                resume_step_d  = succ_step;
                stepm_mode_d   = 1'b0;
`endif
            end else begin
                state_d = succ_state;
                step_d  = succ_step;
            end
        end else begin
            phase_d = phase_q + 4'd1;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!CLEAR_N) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            step_q    <= '0;
            overrun_q <= 1'b0;
            single_q  <= 1'b0;
            run_q     <= RUN;
            stepi_q   <= STEPI;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
            overrun_q <= overrun_d;
            single_q  <= single_d;
            run_q     <= RUN;
            stepi_q   <= STEPI;
        end
    end

    // Strobes are gated by DONE so a terminated EXEC step never issues its strobe.
    always_comb begin
        RUNNING      = (state_q != ST_IDLE);
        OVERRUN      = overrun_q;
        PH           = RUNNING ? (PH_ONE << phase_q) : '0;
        CK_FETCH     = (state_q == ST_FETCH);
        CK_AUTOINC1  = (state_q == ST_AUTOINC1);
        CK_AUTOINC2  = (state_q == ST_AUTOINC2);
        CK_INDIRECT  = (state_q == ST_INDIRECT);
        CK_EXEC      = (state_q == ST_EXEC) ? (EXEC_ONE << step_q) : '0;
        STB_FETCH    = CK_FETCH && last_phase;
        STB_AUTOINC1 = CK_AUTOINC1 && last_phase;
        STB_AUTOINC2 = CK_AUTOINC2 && last_phase;
        STB_INDIRECT = CK_INDIRECT && last_phase;
        STB_EXEC     = (last_phase && !DONE) ? CK_EXEC : '0;
    end

endmodule
